serial_adder_seq: RTL and testbench

Bit-serial N-bit adder: accepts two WIDTH-bit operands plus carry-in over a valid/ready handshake, streams them LSB-first through a single one-bit full-adder cell with a registered carry, and returns the WIDTH-bit sum and carry-out over a second valid/ready handshake. It sits directly upstream of the one-bit full-adder cell it drives, and trades WIDTH cycles of latency for one adder cell of area.

---
 rtl/serial_adder_pkg.sv | 25 ++
 rtl/serial_adder_seq_fa_cell.sv | 21 ++
 rtl/serial_adder_seq.sv | 156 +++++++++++++++
 tb/tb_serial_adder_seq.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// ============================================================================
// Module  : serial_adder_pkg
// Brief   : Shared types and constants for the bit-serial adder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } serial_adder_state_e;

  localparam int SERIAL_ADDER_WIDTH_DEF = 8;

  // One spare bit so the counter can represent WIDTH itself.
  function automatic int serial_adder_cnt_w(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_adder_seq_fa_cell.sv
// ============================================================================
// Module  : fa_cell
// Brief   : Purely combinational one-bit full adder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

`default_nettype wire

// File: rtl/serial_adder_seq.sv
// ============================================================================
// Module  : serial_adder_seq
// Brief   : Bit-serial WIDTH-bit adder, LSB first through one fa_cell, with
//           valid/ready handshakes on operands and result.
//           Optional signed-overflow output: define SERIAL_ADDER_OVF_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_adder_seq
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SERIAL_ADDER_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             busy
);

  localparam int              CNT_W    = serial_adder_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [1:0]      ST_IDLE  = IDLE;
  localparam logic [1:0]      ST_SHIFT = SHIFT;
  localparam logic [1:0]      ST_DONE  = DONE;

  logic [1:0]       state_q,  state_d;
  logic [WIDTH-1:0] a_sh_q,   a_sh_d;
  logic [WIDTH-1:0] b_sh_q,   b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic             carry_q,  carry_d;
  logic             cout_q,   cout_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;

  logic fa_s;
  logic fa_co;

  fa_cell u_fa_cell (
    .a  (a_sh_q[0]),
    .b  (b_sh_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        sum_sh_d = {fa_s, sum_sh_q[WIDTH-1:1]};
        carry_d  = fa_co;
        a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
          cout_d  = fa_co;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  localparam logic [CNT_W-1:0] CNT_PENULT = CNT_W'(WIDTH - 2);

  logic carry_msb_in_q, carry_msb_in_d;
  logic ovf_q, ovf_d;

  // The carry produced by bit WIDTH-2 is the carry entering the sign bit.
  always_comb begin
    carry_msb_in_d = carry_msb_in_q;
    ovf_d          = ovf_q;
    if (state_q == ST_SHIFT) begin
      if (cnt_q == CNT_PENULT) begin
        carry_msb_in_d = fa_co;
      end
      if (cnt_q == CNT_LAST) begin
        ovf_d = carry_msb_in_q ^ fa_co;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_msb_in_q <= 1'b0;
      ovf_q          <= 1'b0;
    end else begin
      carry_msb_in_q <= carry_msb_in_d;
      ovf_q          <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign sum       = sum_sh_q;
  assign cout      = cout_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder_seq.sv
// ============================================================================
// Module  : tb_serial_adder_seq
// Brief   : Self-checking bench for serial_adder_seq (WIDTH=8); honours
//           SERIAL_ADDER_OVF_EN when defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_adder_seq;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;
`endif

  always #5 clk = ~clk;

  serial_adder_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf       (ovf),
`endif
    .busy      (busy)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: result = (a+b+cin) with timestamps for
  // when it must appear and when the result handshake frees the block.
  int               cyc = 0;
  bit               m_idle = 1'b1;
  int               m_done_at = 0;
  logic [WIDTH-1:0] m_sum = '0, p_sum;
  logic             m_cout = 1'b0, p_cout;
  logic             m_ovf = 1'b0, p_ovf;
  logic [WIDTH:0]   tot;
  int               s_int;
  int               n_acc = 0;
  int               acc_cyc[$];

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_idle = 1'b1; m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0;
    end else if (m_idle) begin
      if (in_valid) begin
        tot       = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        s_int     = int'($signed(a)) + int'($signed(b)) + int'(cin);
        p_sum     = tot[WIDTH-1:0];
        p_cout    = tot[WIDTH];
        p_ovf     = (s_int > 127) || (s_int < -128);
        m_idle    = 1'b0;
        m_done_at = cyc + WIDTH;
        n_acc++;
        acc_cyc.push_back(cyc);
      end
    end else if (cyc == m_done_at) begin
      m_sum = p_sum; m_cout = p_cout; m_ovf = p_ovf;
    end else if (cyc > m_done_at && out_ready) begin
      m_idle = 1'b1;
    end
  end

  always @(negedge rst_n) begin
    m_idle = 1'b1; m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0;
  end

  bit exp_ov;
  always @(negedge clk) begin
    if (rst_n) begin
      exp_ov = !m_idle && (cyc >= m_done_at);
      check("in_ready", 64'(in_ready), 64'(m_idle));
      check("out_valid", 64'(out_valid), 64'(exp_ov));
      check("busy", 64'(busy), 64'(!m_idle));
      if (m_idle || exp_ov) begin
        check("sum", 64'(sum), 64'(m_sum));
        check("cout", 64'(cout), 64'(m_cout));
`ifdef SERIAL_ADDER_OVF_EN
        check("ovf", 64'(ovf), 64'(m_ovf));
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_result(input string name, input int acc, input int exp_lat);
    bit seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    if (!seen) begin
      n_vec++; n_err++;
      $display("FAIL %s_timeout: out_valid low after 40 cycles, expected high", name);
    end else begin
      check({name, "_latency"}, 64'(cyc - acc), 64'(exp_lat));
    end
  endtask

  task automatic run_op(input string name, input logic [7:0] ta, input logic [7:0] tb,
                        input logic tc, input logic [7:0] es, input logic ec, input logic eo);
    int acc;
    a = ta; b = tb; cin = tc; in_valid = 1'b1;
    tick();
    acc = cyc;
    in_valid = 1'b0;
    wait_result(name, acc, WIDTH);
    check({name, "_sum"}, 64'(sum), 64'(es));
    check({name, "_cout"}, 64'(cout), 64'(ec));
`ifdef SERIAL_ADDER_OVF_EN
    check({name, "_ovf"}, 64'(ovf), 64'(eo));
`else
    if (eo === 1'bx) $display("unreachable");
`endif
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc;
    int base_idx;
    int tgt;
    logic [7:0] va[4];
    logic [7:0] vb[4];
    logic       vc[4];

    repeat (3) tick();
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
    rst_n = 1'b1;
    tick();

    run_op("add_5a_33", 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1);
    run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
    run_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op("add_80_ff", 8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1);
    run_op("add_10_20", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);

    // Backpressure: hold the result while ignored operand pulses arrive.
    a = 8'h21; b = 8'h42; cin = 1'b1; in_valid = 1'b1;
    tick();
    acc = cyc;
    in_valid = 1'b0;
    wait_result("bp", acc, WIDTH);
    for (int i = 0; i < 5; i++) begin
      tick();
      in_valid = (i % 2 == 0);
      a = 8'hAA; b = 8'h55;
      @(negedge clk);
      check("bp_sum_hold", 64'(sum), 64'h64);
      check("bp_cout_hold", 64'(cout), 64'd0);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_out_valid", 64'(out_valid), 64'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    @(negedge clk);
    check("bp_release_in_ready", 64'(in_ready), 64'd1);
    check("bp_release_out_valid", 64'(out_valid), 64'd0);
    check("bp_idle_sum", 64'(sum), 64'h64);

    // Abort mid-shift.
    a = 8'h0F; b = 8'h0F; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_sum", 64'(sum), 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    run_op("post_abort", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);

    // Back-to-back with both handshakes held high.
    va = '{8'h01, 8'h80, 8'h3C, 8'h55};
    vb = '{8'h02, 8'h80, 8'hC3, 8'h55};
    vc = '{1'b0, 1'b0, 1'b1, 1'b1};
    base_idx = acc_cyc.size();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = va[i]; b = vb[i]; cin = vc[i]; in_valid = 1'b1;
      tgt = n_acc + 1;
      for (int k = 0; k < 30 && n_acc < tgt; k++) tick();
      if (n_acc < tgt) begin
        n_vec++; n_err++;
        $display("FAIL b2b_accept_timeout: op %0d not accepted, expected accept", i);
      end
    end
    in_valid = 1'b0;
    repeat (12) tick();
    out_ready = 1'b0;
    if (acc_cyc.size() == base_idx + 4) begin
      for (int i = 1; i < 4; i++)
        check("b2b_spacing", 64'(acc_cyc[base_idx+i] - acc_cyc[base_idx+i-1]), 64'd10);
    end else begin
      n_vec++; n_err++;
      $display("FAIL b2b_count: %0d accepts, expected 4", acc_cyc.size() - base_idx);
    end
    @(negedge clk);
    check("b2b_last_sum", 64'(sum), 64'hAB);
    check("b2b_last_cout", 64'(cout), 64'd0);
    check("b2b_idle", 64'(in_ready), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
